// File: rtl/t_state_sequencer.sv
// T-state / machine-cycle sequencer for the 8008 core: walks T1..T5, WAIT and STOPPED,
// tracks the machine cycle and its type, and pulses IR load and interrupt acknowledge.
module t_state_sequencer #(
  parameter int PHASES  = 2,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ready,
  input  logic               intr,
  input  logic [1:0]         dec_ncycles,
  input  logic [2:0]         dec_nstates,
  input  logic [1:0]         dec_cyc_type,
  input  logic               dec_halt,
  output logic [STATE_W-1:0] state,
  output logic               sync,
  output logic               adv,
  output logic [1:0]         cycle,
  output logic [1:0]         cyc_type,
  output logic               ld_ir,
  output logic               intr_ack
);

  typedef enum logic [2:0] {
    S_WAIT = 3'b000,
    S_T2   = 3'b001,
    S_T1   = 3'b010,
    S_T1I  = 3'b011,
    S_T3   = 3'b100,
    S_T5   = 3'b101,
    S_STOP = 3'b110,
    S_T4   = 3'b111
  } state_t;

  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
  localparam logic [1:0] PCI = 2'd0;

  // Out-of-range decoder values fold onto the nearest legal count.
  function automatic logic [2:0] clamp_nstates(input logic [2:0] n);
    if (n < 3'd3)      return 3'd3;
    else if (n > 3'd5) return 3'd5;
    else               return n;
  endfunction

  function automatic logic [1:0] clamp_ncycles(input logic [1:0] n);
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

  state_t          cur, nxt;
  logic [PH_W-1:0] phase;
  logic [1:0]      cycle_q, nxt_cycle;
  logic [1:0]      type_q, nxt_type;
  logic            intr_pend, pend_eff, end_cyc;
  logic [2:0]      nst;
  logic [1:0]      ncyc;

  assign adv      = (phase == PH_LAST);
  assign sync     = (phase == '0);
  assign state    = STATE_W'(cur);
  assign cycle    = cycle_q;
  assign cyc_type = type_q;
  assign intr_ack = (cur == S_T1I) && (phase == '0);
  // An interrupt arriving on the boundary clock itself must still be honoured.
  assign pend_eff = intr_pend | intr;
  assign nst      = clamp_nstates(dec_nstates);
  assign ncyc     = clamp_ncycles(dec_ncycles);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= S_T1;
      phase     <= '0;
      cycle_q   <= 2'd0;
      type_q    <= PCI;
      intr_pend <= 1'b0;
    end else begin
      phase   <= adv ? '0 : phase + PH_W'(1);
      cur     <= nxt;
      cycle_q <= nxt_cycle;
      type_q  <= nxt_type;
      if (adv && nxt == S_T1I) intr_pend <= 1'b0;
      else if (intr)           intr_pend <= 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    nxt_cycle = cycle_q;
    nxt_type  = type_q;
    ld_ir     = 1'b0;
    end_cyc   = 1'b0;
    if (adv) begin
      case (cur)
        S_T1, S_T1I:   nxt = S_T2;
        S_T2, S_WAIT:  nxt = ready ? S_T3 : S_WAIT;
        S_T3: begin
          ld_ir = (cycle_q == 2'd0);
          if (cycle_q == 2'd0 && type_q == PCI && dec_halt) nxt = S_STOP;
          else if (nst == 3'd3)                             end_cyc = 1'b1;
          else                                              nxt = S_T4;
        end
        S_T4: begin
          if (nst == 3'd4) end_cyc = 1'b1;
          else             nxt = S_T5;
        end
        S_T5:          end_cyc = 1'b1;
        S_STOP: begin
          if (pend_eff) begin
            nxt       = S_T1I;
            nxt_cycle = 2'd0;
            nxt_type  = PCI;
          end
        end
        default:       nxt = S_T1;
      endcase
      // Interrupts are only taken between instructions, never between machine cycles.
      if (end_cyc) begin
        if (({1'b0, cycle_q} + 3'd1) < {1'b0, ncyc}) begin
          nxt_cycle = cycle_q + 2'd1;
          nxt_type  = dec_cyc_type;
          nxt       = S_T1;
        end else begin
          nxt_cycle = 2'd0;
          nxt_type  = PCI;
          nxt       = pend_eff ? S_T1I : S_T1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t_state_sequencer.sv
// Directed bench for t_state_sequencer: walks each scenario clock by clock and
// compares state/sync/adv/cycle/type/pulses against hand-computed tables.
module tb_t_state_sequencer;

  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam logic [2:0] ST_T2   = 3'b001;
  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T1I  = 3'b011;
  localparam logic [2:0] ST_T3   = 3'b100;
  localparam logic [2:0] ST_T5   = 3'b101;
  localparam logic [2:0] ST_STOP = 3'b110;
  localparam logic [2:0] ST_T4   = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n, ready, intr, dec_halt;
  logic [1:0] dec_ncycles, dec_cyc_type;
  logic [2:0] dec_nstates;
  logic [2:0] state;
  logic       sync, adv, ld_ir, intr_ack;
  logic [1:0] cycle, cyc_type;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  t_state_sequencer #(.PHASES(2), .STATE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .intr(intr),
    .dec_ncycles(dec_ncycles), .dec_nstates(dec_nstates),
    .dec_cyc_type(dec_cyc_type), .dec_halt(dec_halt),
    .state(state), .sync(sync), .adv(adv), .cycle(cycle),
    .cyc_type(cyc_type), .ld_ir(ld_ir), .intr_ack(intr_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t1(input string tag);
    int n;
    n = 0;
    while (!(state === ST_T1 && sync === 1'b1) && n < 40) begin
      tick;
      n++;
    end
    n_cmp++;
    if (state !== ST_T1 || sync !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_return_t1 got state=%b sync=%b want state=%b sync=1", tag, state, sync, ST_T1);
    end
  endtask

  task automatic test_reset;
    ready = 1'b1; intr = 1'b0; dec_halt = 1'b0;
    dec_ncycles = 2'd1; dec_nstates = 3'd5; dec_cyc_type = 2'd0;
    rst_n = 1'b0;
    tick;
    tick;
    n_cmp++; if (state !== ST_T1)  begin n_bad++; $display("FAIL reset_state got %b want %b", state, ST_T1); end
    n_cmp++; if (sync !== 1'b1)    begin n_bad++; $display("FAIL reset_sync got %b want 1", sync); end
    n_cmp++; if (adv !== 1'b0)     begin n_bad++; $display("FAIL reset_adv got %b want 0", adv); end
    n_cmp++; if (cycle !== 2'd0)   begin n_bad++; $display("FAIL reset_cycle got %0d want 0", cycle); end
    n_cmp++; if (cyc_type !== 2'd0) begin n_bad++; $display("FAIL reset_cyc_type got %0d want 0", cyc_type); end
    n_cmp++; if (ld_ir !== 1'b0)   begin n_bad++; $display("FAIL reset_ld_ir got %b want 0", ld_ir); end
    n_cmp++; if (intr_ack !== 1'b0) begin n_bad++; $display("FAIL reset_intr_ack got %b want 0", intr_ack); end
    rst_n = 1'b1;
  endtask

  task automatic test_five_states;
    logic [2:0] exp_st [0:10];
    exp_st = '{ST_T1, ST_T1, ST_T2, ST_T2, ST_T3, ST_T3, ST_T4, ST_T4, ST_T5, ST_T5, ST_T1};
    ready = 1'b1; dec_ncycles = 2'd1; dec_nstates = 3'd5;
    for (int k = 0; k <= 10; k++) begin
      n_cmp++; if (state !== exp_st[k]) begin n_bad++; $display("FAIL five_state k=%0d got %b want %b", k, state, exp_st[k]); end
      n_cmp++; if (sync !== (k % 2 == 0)) begin n_bad++; $display("FAIL five_sync k=%0d got %b want %b", k, sync, (k % 2 == 0)); end
      n_cmp++; if (adv !== (k % 2 == 1)) begin n_bad++; $display("FAIL five_adv k=%0d got %b want %b", k, adv, (k % 2 == 1)); end
      n_cmp++; if (ld_ir !== (k == 5)) begin n_bad++; $display("FAIL five_ld_ir k=%0d got %b want %b", k, ld_ir, (k == 5)); end
      if (k < 10) tick;
    end
  endtask

  task automatic test_wait;
    logic [2:0] exp_st [0:12];
    exp_st = '{ST_T1, ST_T1, ST_T2, ST_T2, ST_WAIT, ST_WAIT, ST_WAIT, ST_WAIT,
               ST_WAIT, ST_WAIT, ST_T3, ST_T3, ST_T1};
    ready = 1'b0; dec_ncycles = 2'd1; dec_nstates = 3'd3;
    for (int k = 0; k <= 12; k++) begin
      n_cmp++; if (state !== exp_st[k]) begin n_bad++; $display("FAIL wait_state k=%0d got %b want %b", k, state, exp_st[k]); end
      n_cmp++; if (ld_ir !== (k == 11)) begin n_bad++; $display("FAIL wait_ld_ir k=%0d got %b want %b", k, ld_ir, (k == 11)); end
      if (k == 8) ready = 1'b1;
      if (k < 12) tick;
    end
  endtask

  task automatic test_multi_cycle;
    logic [2:0] exp_st [0:2];
    logic [1:0] exp_cy [0:3];
    logic [1:0] exp_ty [0:3];
    exp_st = '{ST_T1, ST_T2, ST_T3};
    exp_cy = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_ty = '{2'd0, 2'd1, 2'd3, 2'd0};
    ready = 1'b1; dec_ncycles = 2'd3; dec_nstates = 3'd3; dec_cyc_type = 2'd1;
    for (int k = 0; k <= 18; k++) begin
      n_cmp++; if (state !== exp_st[(k % 6) / 2]) begin n_bad++; $display("FAIL multi_state k=%0d got %b want %b", k, state, exp_st[(k % 6) / 2]); end
      n_cmp++; if (cycle !== exp_cy[k / 6]) begin n_bad++; $display("FAIL multi_cycle k=%0d got %0d want %0d", k, cycle, exp_cy[k / 6]); end
      n_cmp++; if (cyc_type !== exp_ty[k / 6]) begin n_bad++; $display("FAIL multi_type k=%0d got %0d want %0d", k, cyc_type, exp_ty[k / 6]); end
      n_cmp++; if (ld_ir !== (k == 5)) begin n_bad++; $display("FAIL multi_ld_ir k=%0d got %b want %b", k, ld_ir, (k == 5)); end
      if (k == 6) dec_cyc_type = 2'd3;
      if (k < 18) tick;
    end
    dec_ncycles = 2'd1; dec_cyc_type = 2'd0;
  endtask

  task automatic test_intr_deferred;
    logic [2:0] exp_st [0:14];
    exp_st = '{ST_T1, ST_T1, ST_T2, ST_T2, ST_T3, ST_T3, ST_T1, ST_T1,
               ST_T2, ST_T2, ST_T3, ST_T3, ST_T1I, ST_T1I, ST_T2};
    ready = 1'b1; dec_ncycles = 2'd2; dec_nstates = 3'd3; dec_cyc_type = 2'd1;
    for (int k = 0; k <= 14; k++) begin
      n_cmp++; if (state !== exp_st[k]) begin n_bad++; $display("FAIL intr_state k=%0d got %b want %b", k, state, exp_st[k]); end
      n_cmp++; if (intr_ack !== (k == 12)) begin n_bad++; $display("FAIL intr_ack k=%0d got %b want %b", k, intr_ack, (k == 12)); end
      n_cmp++; if (cycle !== ((k >= 6 && k < 12) ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL intr_cycle k=%0d got %0d", k, cycle); end
      n_cmp++; if ((ld_ir & intr_ack) !== 1'b0) begin n_bad++; $display("FAIL intr_pulse_overlap k=%0d got 1 want 0", k); end
      if (k == 4) intr = 1'b1;
      if (k == 5) intr = 1'b0;
      if (k < 14) tick;
    end
    dec_ncycles = 2'd1; dec_cyc_type = 2'd0;
    wait_t1("intr");
  endtask

  task automatic test_halt;
    logic [2:0] exp;
    ready = 1'b1; dec_ncycles = 2'd1; dec_nstates = 3'd3; dec_halt = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      exp = (k < 2) ? ST_T1 : (k < 4) ? ST_T2 : (k < 6) ? ST_T3 : (k < 28) ? ST_STOP : ST_T1I;
      n_cmp++; if (state !== exp) begin n_bad++; $display("FAIL halt_state k=%0d got %b want %b", k, state, exp); end
      n_cmp++; if (sync !== (k % 2 == 0)) begin n_bad++; $display("FAIL halt_sync k=%0d got %b want %b", k, sync, (k % 2 == 0)); end
      n_cmp++; if (intr_ack !== (k == 28)) begin n_bad++; $display("FAIL halt_intr_ack k=%0d got %b want %b", k, intr_ack, (k == 28)); end
      n_cmp++; if (cycle !== 2'd0) begin n_bad++; $display("FAIL halt_cycle k=%0d got %0d want 0", k, cycle); end
      if (k == 6)  dec_halt = 1'b0;
      if (k == 26) intr = 1'b1;
      if (k == 27) intr = 1'b0;
      if (k < 28) tick;
    end
    wait_t1("halt");
  endtask

  task automatic test_reset_in_wait;
    logic [2:0] exp_st [0:6];
    exp_st = '{ST_T1, ST_T1, ST_T2, ST_T2, ST_T3, ST_T3, ST_T1};
    ready = 1'b0; dec_ncycles = 2'd1; dec_nstates = 3'd3;
    tick; tick; tick; tick;
    n_cmp++; if (state !== ST_WAIT) begin n_bad++; $display("FAIL rstw_enter_wait got %b want %b", state, ST_WAIT); end
    intr = 1'b1;
    tick;
    intr = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; ready = 1'b1;
    n_cmp++; if (state !== ST_T1) begin n_bad++; $display("FAIL rstw_state got %b want %b", state, ST_T1); end
    n_cmp++; if (sync !== 1'b1)   begin n_bad++; $display("FAIL rstw_sync got %b want 1", sync); end
    for (int k = 0; k <= 6; k++) begin
      n_cmp++; if (state !== exp_st[k]) begin n_bad++; $display("FAIL rstw_seq k=%0d got %b want %b", k, state, exp_st[k]); end
      n_cmp++; if (intr_ack !== 1'b0) begin n_bad++; $display("FAIL rstw_intr_ack k=%0d got %b want 0", k, intr_ack); end
      if (k < 6) tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_five_states;
    test_wait;
    test_multi_cycle;
    test_intr_deferred;
    test_halt;
    test_reset_in_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
